// File: rtl/stage1_decode_issue.sv
// stage1_decode_issue: decode/issue stage feeding the Stage2 ALU.
// Instruction words are queued in a small FIFO. The head is decoded into ALU
// control fields, and its operands are read from an 8-entry register file.
// A busy-bit scoreboard holds the head back on read-after-write hazards until
// downstream writeback clears the destination register.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   instr/instr_valid   incoming instruction word; instr_ready = FIFO not full
//   flush               discards queued words
//   wb_en/addr/data     writeback from downstream; clears busy, writes regfile
//   aluin1/aluin2       registered operands (rs1, rs2 or sign-extended imm16)
//   operation/opselect/shift_number/rd_out  registered decoded fields
//   enable_arith/enable_shift                single-cycle issue strobes
//   illegal_instr       one-cycle pulse when an illegal opselect is dropped
module stage1_decode_issue #(
  parameter int unsigned N          = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NREG       = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] instr,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic         flush,
  input  logic         wb_en,
  input  logic [2:0]   wb_addr,
  input  logic [N-1:0] wb_data,
  output logic [N-1:0] aluin1,
  output logic [N-1:0] aluin2,
  output logic [2:0]   operation,
  output logic [2:0]   opselect,
  output logic [4:0]   shift_number,
  output logic         enable_arith,
  output logic         enable_shift,
  output logic [2:0]   rd_out,
  output logic         illegal_instr
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] OPS_SHIFT = 3'b000;
  localparam logic [2:0] OPS_ARITH = 3'b001;
  localparam logic [2:0] OPS_LOGIC = 3'b010;
  localparam logic [2:0] OPS_NOP   = 3'b111;

  typedef struct packed {
    logic [2:0]  opsel;
    logic [2:0]  op;
    logic        imm_flag;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm16;
  } instr_t;

  // Storage
  logic [N-1:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic [N-1:0]    rf_q [NREG];
  logic [NREG-1:0] busy_q;

  // Combinational decode / control
  instr_t          hd;
  logic            head_valid;
  logic            is_exec;
  logic            is_illegal;
  logic            uses_rs2;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] busy_eff;
  logic            stall;
  logic            issue;
  logic            drop;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count_d;
  logic [NREG-1:0] busy_d;
  logic [N-1:0]    rs1_val;
  logic [N-1:0]    rs2_val;
  logic [N-1:0]    op2_val;

  // Head decode, hazard check and FIFO/scoreboard next state
  always_comb begin
    hd         = instr_t'(fifo_mem[rd_ptr_q][31:0]);
    head_valid = (count_q != '0);
    is_exec    = (hd.opsel == OPS_SHIFT) || (hd.opsel == OPS_ARITH) ||
                 (hd.opsel == OPS_LOGIC);
    is_illegal = !is_exec && (hd.opsel != OPS_NOP);
    uses_rs2   = ((hd.opsel == OPS_ARITH) || (hd.opsel == OPS_LOGIC)) && !hd.imm_flag;

    // A writeback this cycle releases its register for the hazard check.
    clr_mask   = wb_en ? (NREG'(1) << wb_addr) : '0;
    busy_eff   = busy_q & ~clr_mask;

    stall = head_valid && is_exec &&
            (busy_eff[hd.rs1] || (uses_rs2 && busy_eff[hd.rs2]));
    issue = head_valid && is_exec && !stall && !flush;
    drop  = head_valid && !is_exec && !flush;
    pop   = issue || drop;
    push  = instr_valid && instr_ready && !flush;

    if (flush) count_d = '0;
    else       count_d = count_q + CW'(push) - CW'(pop);

    // Set-on-issue wins over a same-cycle writeback clear.
    busy_d = busy_eff;
    if (issue && (hd.rd != 3'd0)) busy_d[hd.rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Operand read with writeback bypass; r0 reads as zero
  always_comb begin
    rs1_val = rf_q[hd.rs1];
    if (wb_en && (wb_addr == hd.rs1)) rs1_val = wb_data;
    if (hd.rs1 == 3'd0)               rs1_val = '0;

    rs2_val = rf_q[hd.rs2];
    if (wb_en && (wb_addr == hd.rs2)) rs2_val = wb_data;
    if (hd.rs2 == 3'd0)               rs2_val = '0;

    op2_val = hd.imm_flag ? {{(N-16){hd.imm16[15]}}, hd.imm16} : rs2_val;
  end

  // FIFO storage (no reset needed; validity tracked by count)
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= instr;
  end

  // FIFO pointers, scoreboard and register file
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      instr_ready <= 1'b1;
      busy_q      <= '0;
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else begin
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q     <= count_d;
      instr_ready <= (count_d != CW'(FIFO_DEPTH));
      busy_q      <= busy_d;
      if (wb_en && (wb_addr != 3'd0)) rf_q[wb_addr] <= wb_data;
    end
  end

  // Issue outputs: strobes pulse on issue, other fields hold between issues
  always_ff @(posedge clock) begin
    if (!reset) begin
      aluin1        <= '0;
      aluin2        <= '0;
      operation     <= '0;
      opselect      <= '0;
      shift_number  <= '0;
      enable_arith  <= 1'b0;
      enable_shift  <= 1'b0;
      rd_out        <= '0;
      illegal_instr <= 1'b0;
    end else begin
      enable_arith  <= issue && (hd.opsel != OPS_SHIFT);
      enable_shift  <= issue && (hd.opsel == OPS_SHIFT);
      illegal_instr <= drop && is_illegal;
      if (issue) begin
        aluin1       <= rs1_val;
        aluin2       <= op2_val;
        operation    <= hd.op;
        opselect     <= hd.opsel;
        shift_number <= hd.imm16[4:0];
        rd_out       <= hd.rd;
      end
    end
  end

endmodule

// File: tb/tb_stage1_decode_issue.sv
// Directed testbench for stage1_decode_issue.
module tb_stage1_decode_issue;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        flush;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] aluin1, aluin2;
  logic [2:0]  operation, opselect, rd_out;
  logic [4:0]  shift_number;
  logic        enable_arith, enable_shift, illegal_instr;

  int total = 0;
  int bad   = 0;

  stage1_decode_issue #(.N(32), .FIFO_DEPTH(4), .NREG(8)) dut (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .aluin1(aluin1), .aluin2(aluin2), .operation(operation),
    .opselect(opselect), .shift_number(shift_number), .enable_arith(enable_arith),
    .enable_shift(enable_shift), .rd_out(rd_out), .illegal_instr(illegal_instr)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [2:0] os, input logic [2:0] op,
                                     input logic imm, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [15:0] i16);
    return {os, op, imm, rd, rs1, rs2, i16};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wb(input logic [2:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; instr = '0; instr_valid = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    tick(); tick();
    total++; if (enable_arith !== 1'b0) begin bad++; $display("FAIL rst_en_arith got=%0h exp=0", enable_arith); end
    total++; if (enable_shift !== 1'b0) begin bad++; $display("FAIL rst_en_shift got=%0h exp=0", enable_shift); end
    total++; if (aluin1 !== 32'h0 || aluin2 !== 32'h0) begin bad++; $display("FAIL rst_aluin got=%0h/%0h exp=0/0", aluin1, aluin2); end
    total++; if (rd_out !== 3'd0 || opselect !== 3'd0 || illegal_instr !== 1'b0) begin bad++; $display("FAIL rst_fields got rd=%0h os=%0h ill=%0h exp=0", rd_out, opselect, illegal_instr); end
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0h exp=1", instr_ready); end
    reset = 1'b1;
  endtask

  task automatic test_add();
    instr = mk(3'b001, 3'b000, 1'b1, 3'd1, 3'd0, 3'd0, 16'h0005); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    total++; if (enable_arith !== 1'b0) begin bad++; $display("FAIL add_early got=%0h exp=0", enable_arith); end
    tick();
    total++; if (enable_arith !== 1'b1) begin bad++; $display("FAIL add_en got=%0h exp=1", enable_arith); end
    total++; if (aluin1 !== 32'h0 || aluin2 !== 32'h5) begin bad++; $display("FAIL add_ops got=%0h/%0h exp=0/5", aluin1, aluin2); end
    total++; if (rd_out !== 3'd1 || opselect !== 3'b001) begin bad++; $display("FAIL add_rd got rd=%0h os=%0h exp=1/1", rd_out, opselect); end
    tick();
    total++; if (enable_arith !== 1'b0) begin bad++; $display("FAIL add_strobe got=%0h exp=0", enable_arith); end
    wb(3'd1, 32'h0);
  endtask

  task automatic test_dependent();
    instr = mk(3'b001, 3'b000, 1'b1, 3'd1, 3'd0, 3'd0, 16'h0007); instr_valid = 1'b1;
    tick();
    instr = mk(3'b001, 3'b001, 1'b0, 3'd3, 3'd1, 3'd0, 16'h0000);
    tick();
    instr_valid = 1'b0;
    total++; if (enable_arith !== 1'b1 || rd_out !== 3'd1 || aluin2 !== 32'h7) begin bad++; $display("FAIL dep_first got en=%0h rd=%0h a2=%0h exp=1/1/7", enable_arith, rd_out, aluin2); end
    tick();
    total++; if (enable_arith !== 1'b0 || enable_shift !== 1'b0 || rd_out !== 3'd1) begin bad++; $display("FAIL dep_stall got en=%0h/%0h rd=%0h exp=0/0/1", enable_arith, enable_shift, rd_out); end
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 32'h1234;
    tick();
    wb_en = 1'b0;
    total++; if (enable_arith !== 1'b1 || aluin1 !== 32'h1234 || aluin2 !== 32'h0) begin bad++; $display("FAIL dep_bypass got en=%0h a1=%0h a2=%0h exp=1/1234/0", enable_arith, aluin1, aluin2); end
    total++; if (rd_out !== 3'd3 || operation !== 3'b001) begin bad++; $display("FAIL dep_fields got rd=%0h op=%0h exp=3/1", rd_out, operation); end
    wb(3'd3, 32'h0);
  endtask

  task automatic test_shift();
    wb(3'd2, 32'h0000000F);
    instr = mk(3'b000, 3'b010, 1'b0, 3'd4, 3'd2, 3'd0, 16'h0003); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    total++; if (enable_shift !== 1'b1 || enable_arith !== 1'b0) begin bad++; $display("FAIL shift_en got sh=%0h ar=%0h exp=1/0", enable_shift, enable_arith); end
    total++; if (aluin1 !== 32'hF || shift_number !== 5'd3 || rd_out !== 3'd4 || opselect !== 3'b000) begin bad++; $display("FAIL shift_fields got a1=%0h sn=%0d rd=%0h os=%0h exp=f/3/4/0", aluin1, shift_number, rd_out, opselect); end
    wb(3'd4, 32'h0);
    total++; if (enable_shift !== 1'b0) begin bad++; $display("FAIL shift_strobe got=%0h exp=0", enable_shift); end
  endtask

  task automatic test_full_wrap();
    instr = mk(3'b001, 3'b000, 1'b1, 3'd5, 3'd0, 3'd0, 16'h0001); instr_valid = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      instr = mk(3'b001, 3'b000, 1'b1, 3'd0, 3'd5, 3'd0, 16'h0010 + 16'(k));
      tick();
      if (k == 2) begin
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL full_ready3 got=%0h exp=1", instr_ready); end
      end
    end
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL full_ready4 got=%0h exp=0", instr_ready); end
    instr = mk(3'b001, 3'b000, 1'b1, 3'd0, 3'd5, 3'd0, 16'h0014);
    tick();
    instr_valid = 1'b0;
    total++; if (instr_ready !== 1'b0 || enable_arith !== 1'b0) begin bad++; $display("FAIL full_hold got rdy=%0h en=%0h exp=0/0", instr_ready, enable_arith); end
    wb(3'd5, 32'h50);
    total++; if (enable_arith !== 1'b1 || aluin1 !== 32'h50 || aluin2 !== 32'h10 || instr_ready !== 1'b1) begin bad++; $display("FAIL full_pop got en=%0h a1=%0h a2=%0h rdy=%0h exp=1/50/10/1", enable_arith, aluin1, aluin2, instr_ready); end
    for (int k = 1; k < 4; k++) begin
      tick();
      total++; if (enable_arith !== 1'b1 || aluin2 !== 32'h10 + 32'(k)) begin bad++; $display("FAIL full_drain%0d got en=%0h a2=%0h exp=1/%0h", k, enable_arith, aluin2, 32'h10 + 32'(k)); end
    end
    tick();
    total++; if (enable_arith !== 1'b0) begin bad++; $display("FAIL full_fifth got en=%0h a2=%0h exp=0", enable_arith, aluin2); end
    for (int i = 0; i < 10; i++) begin
      instr = mk(3'b001, 3'b000, 1'b1, 3'd0, 3'd0, 3'd0, 16'h0020 + 16'(i)); instr_valid = 1'b1;
      tick();
      if (i > 0) begin
        total++; if (enable_arith !== 1'b1 || aluin2 !== 32'h20 + 32'(i - 1) || instr_ready !== 1'b1) begin bad++; $display("FAIL wrap%0d got en=%0h a2=%0h rdy=%0h exp=1/%0h/1", i, enable_arith, aluin2, instr_ready, 32'h20 + 32'(i - 1)); end
      end
    end
    instr_valid = 1'b0;
    tick();
    total++; if (enable_arith !== 1'b1 || aluin2 !== 32'h29) begin bad++; $display("FAIL wrap_last got en=%0h a2=%0h exp=1/29", enable_arith, aluin2); end
    tick();
    total++; if (enable_arith !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%0h exp=0", enable_arith); end
  endtask

  task automatic test_illegal_nop();
    instr = mk(3'b101, 3'b000, 1'b0, 3'd6, 3'd0, 3'd0, 16'h0000); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    total++; if (illegal_instr !== 1'b1 || enable_arith !== 1'b0 || enable_shift !== 1'b0) begin bad++; $display("FAIL ill_pulse got ill=%0h en=%0h/%0h exp=1/0/0", illegal_instr, enable_arith, enable_shift); end
    instr = mk(3'b001, 3'b000, 1'b1, 3'd0, 3'd6, 3'd0, 16'h0042); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    total++; if (illegal_instr !== 1'b0) begin bad++; $display("FAIL ill_once got=%0h exp=0", illegal_instr); end
    tick();
    total++; if (enable_arith !== 1'b1 || aluin2 !== 32'h42 || opselect !== 3'b001) begin bad++; $display("FAIL ill_nobusy got en=%0h a2=%0h os=%0h exp=1/42/1", enable_arith, aluin2, opselect); end
    instr = mk(3'b111, 3'b000, 1'b0, 3'd7, 3'd0, 3'd0, 16'h0000); instr_valid = 1'b1;
    tick();
    instr = mk(3'b001, 3'b000, 1'b1, 3'd0, 3'd7, 3'd0, 16'h0077);
    tick();
    instr_valid = 1'b0;
    total++; if (illegal_instr !== 1'b0 || enable_arith !== 1'b0 || enable_shift !== 1'b0) begin bad++; $display("FAIL nop_quiet got ill=%0h en=%0h/%0h exp=0/0/0", illegal_instr, enable_arith, enable_shift); end
    tick();
    total++; if (enable_arith !== 1'b1 || aluin2 !== 32'h77) begin bad++; $display("FAIL nop_popped got en=%0h a2=%0h exp=1/77", enable_arith, aluin2); end
  endtask

  task automatic test_flush();
    instr = mk(3'b001, 3'b000, 1'b1, 3'd1, 3'd0, 3'd0, 16'h0001); instr_valid = 1'b1;
    tick();
    instr = mk(3'b001, 3'b000, 1'b1, 3'd0, 3'd1, 3'd0, 16'h0001);
    tick(); tick(); tick();
    instr_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (enable_arith !== 1'b0 || instr_ready !== 1'b1) begin bad++; $display("FAIL flush_bubble got en=%0h rdy=%0h exp=0/1", enable_arith, instr_ready); end
    instr = mk(3'b001, 3'b000, 1'b1, 3'd0, 3'd1, 3'd0, 16'h0099); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    total++; if (enable_arith !== 1'b0) begin bad++; $display("FAIL flush_busy_kept got en=%0h exp=0", enable_arith); end
    wb(3'd1, 32'hAB);
    total++; if (enable_arith !== 1'b1 || aluin1 !== 32'hAB || aluin2 !== 32'h99) begin bad++; $display("FAIL flush_probe got en=%0h a1=%0h a2=%0h exp=1/ab/99", enable_arith, aluin1, aluin2); end
  endtask

  task automatic test_reset_mid_stall();
    instr = mk(3'b001, 3'b000, 1'b1, 3'd2, 3'd0, 3'd0, 16'h0000); instr_valid = 1'b1;
    tick();
    instr = mk(3'b001, 3'b000, 1'b1, 3'd0, 3'd2, 3'd0, 16'h0005);
    tick();
    instr_valid = 1'b0;
    tick();
    total++; if (enable_arith !== 1'b0) begin bad++; $display("FAIL mid_stall got en=%0h exp=0", enable_arith); end
    reset = 1'b0; wb_en = 1'b1; wb_addr = 3'd2; wb_data = 32'h55;
    tick();
    reset = 1'b1; wb_en = 1'b0;
    total++; if (enable_arith !== 1'b0 || aluin1 !== 32'h0 || aluin2 !== 32'h0 || rd_out !== 3'd0 || instr_ready !== 1'b1) begin bad++; $display("FAIL mid_reset got en=%0h a1=%0h a2=%0h rd=%0h rdy=%0h exp=0/0/0/0/1", enable_arith, aluin1, aluin2, rd_out, instr_ready); end
    instr = mk(3'b001, 3'b000, 1'b1, 3'd0, 3'd2, 3'd0, 16'h0066); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    total++; if (enable_arith !== 1'b0) begin bad++; $display("FAIL mid_fifo_clear got en=%0h a2=%0h exp=0", enable_arith, aluin2); end
    tick();
    total++; if (enable_arith !== 1'b1 || aluin1 !== 32'h0 || aluin2 !== 32'h66) begin bad++; $display("FAIL mid_after got en=%0h a1=%0h a2=%0h exp=1/0/66", enable_arith, aluin1, aluin2); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_dependent();
    test_shift();
    test_full_wrap();
    test_illegal_nop();
    test_flush();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
